// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcodes,
// datapath mux selects, ALU operations and func3 codes.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEM_ADR,
      S_MEM_READ,
      S_MEM_WB,
      S_MEM_WRITE,
      S_EXEC_R,
      S_EXEC_I,
      S_ALU_WB,
      S_JAL,
      S_JALR,
      S_JALR_PC,
      S_BRANCH,
      S_LUI
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R_TYPE = 7'b0110011;
   localparam logic [6:0] OP_I_TYPE = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b100,
      ALU_XOR = 3'b101
   } alu_ctrl_t;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_J = 3'b011,
      IMM_U = 3'b100
   } imm_src_t;

   typedef enum logic [1:0] {
      RES_ALU_OUT = 2'b00,
      RES_DATA    = 2'b01,
      RES_ALU     = 2'b10,
      RES_IMM     = 2'b11
   } result_src_t;

   typedef enum logic [1:0] {
      SRC_A_PC     = 2'b00,
      SRC_A_OLD_PC = 2'b01,
      SRC_A_REG    = 2'b10
   } alu_src_a_t;

   typedef enum logic [1:0] {
      SRC_B_REG  = 2'b00,
      SRC_B_IMM  = 2'b01,
      SRC_B_FOUR = 2'b10
   } alu_src_b_t;

   // Which ALU decode rule applies in the current state.
   typedef enum logic [1:0] {
      ALU_CLASS_ADD,
      ALU_CLASS_SUB,
      ALU_CLASS_R,
      ALU_CLASS_I
   } alu_class_t;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;
   localparam logic [2:0] F3_BLT = 3'b100;
   localparam logic [2:0] F3_BGE = 3'b101;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   function automatic imm_src_t decode_imm_src(input logic [6:0] op_code);
      case (op_code)
         OP_STORE:  return IMM_S;
         OP_BRANCH: return IMM_B;
         OP_JAL:    return IMM_J;
         OP_LUI:    return IMM_U;
         default:   return IMM_I;
      endcase
   endfunction

   function automatic logic branch_taken(input logic [2:0] func3,
                                         input logic zero, input logic neg);
      case (func3)
         F3_BEQ:  return zero;
         F3_BNE:  return !zero;
         F3_BLT:  return neg;
         F3_BGE:  return !neg;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/multi_alu_decoder.sv
// Selects the ALU operation from the state's decode class and the func fields.
module multi_alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  alu_class_t  alu_class,
   input  logic [2:0]  func3,
   input  logic [6:0]  func7,
   output logic [2:0]  alu_control
);

   // Only func7[5] distinguishes add/sub; the other bits are don't-care here.
   logic unused_func7;
   assign unused_func7 = ^{func7[6], func7[4:0]};

   // NOTE: every path assigns alu_control first, so no latch is inferred.
   always_comb begin
      alu_control = ALU_ADD;
      case (alu_class)
         ALU_CLASS_SUB: alu_control = ALU_SUB;
         ALU_CLASS_R,
         ALU_CLASS_I: begin
            case (func3)
               F3_ADD_SUB: alu_control = (alu_class == ALU_CLASS_R && func7[5]) ? ALU_SUB : ALU_ADD;
               F3_AND:     alu_control = ALU_AND;
               F3_OR:      alu_control = ALU_OR;
               F3_SLT:     alu_control = ALU_SLT;
               F3_XOR:     alu_control = ALU_XOR;
               default:    alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multi_cycle_controller.sv
// Moore FSM that steps a shared-resource multi-cycle RV32I datapath through
// fetch, decode, execute, memory and writeback.
module multi_cycle_controller
   import riscv_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  op_code,
   input  logic [2:0]  func3,
   input  logic [6:0]  func7,
   input  logic        zero,
   input  logic        neg,
   output logic        pc_write,
   output logic        adr_src,
   output logic        mem_write,
   output logic        ir_write,
   output logic        reg_write,
   output logic [1:0]  result_src,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [2:0]  imm_src,
   output logic [2:0]  alu_control
);

   state_t     state;
   alu_class_t alu_class;

   // NOTE: state is sequential, so it only ever takes non-blocking assignments.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FETCH;
      end else begin
         case (state)
            S_FETCH:  state <= S_DECODE;
            S_DECODE: begin
               case (op_code)
                  OP_LOAD,
                  OP_STORE:  state <= S_MEM_ADR;
                  OP_R_TYPE: state <= S_EXEC_R;
                  OP_I_TYPE: state <= S_EXEC_I;
                  OP_JAL:    state <= S_JAL;
                  OP_JALR:   state <= S_JALR;
                  OP_BRANCH: state <= S_BRANCH;
                  OP_LUI:    state <= S_LUI;
                  default:   state <= S_FETCH;
               endcase
            end
            S_MEM_ADR:   state <= (op_code == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state <= S_MEM_WB;
            S_MEM_WB:    state <= S_FETCH;
            S_MEM_WRITE: state <= S_FETCH;
            S_EXEC_R:    state <= S_ALU_WB;
            S_EXEC_I:    state <= S_ALU_WB;
            S_ALU_WB:    state <= S_FETCH;
            S_JAL:       state <= S_ALU_WB;
            S_JALR:      state <= S_JALR_PC;
            S_JALR_PC:   state <= S_ALU_WB;
            S_BRANCH:    state <= S_FETCH;
            S_LUI:       state <= S_FETCH;
            default:     state <= S_FETCH;
         endcase
      end
   end

   always_comb begin
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = RES_ALU_OUT;
      alu_src_a  = SRC_A_PC;
      alu_src_b  = SRC_B_REG;
      alu_class  = ALU_CLASS_ADD;
      case (state)
         S_FETCH: begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            alu_src_b  = SRC_B_FOUR;
            result_src = RES_ALU;
         end
         // ALUOut captures OldPC + imm for branches and jal.
         S_DECODE: begin
            alu_src_a = SRC_A_OLD_PC;
            alu_src_b = SRC_B_IMM;
         end
         S_MEM_ADR, S_JALR: begin
            alu_src_a = SRC_A_REG;
            alu_src_b = SRC_B_IMM;
         end
         S_MEM_READ: adr_src = 1'b1;
         S_MEM_WB: begin
            result_src = RES_DATA;
            reg_write  = 1'b1;
         end
         S_MEM_WRITE: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
         end
         S_EXEC_R: begin
            alu_src_a = SRC_A_REG;
            alu_class = ALU_CLASS_R;
         end
         S_EXEC_I: begin
            alu_src_a = SRC_A_REG;
            alu_src_b = SRC_B_IMM;
            alu_class = ALU_CLASS_I;
         end
         S_ALU_WB: reg_write = 1'b1;
         // PC takes the target from ALUOut while the ALU forms the link value.
         S_JAL, S_JALR_PC: begin
            pc_write  = 1'b1;
            alu_src_a = SRC_A_OLD_PC;
            alu_src_b = SRC_B_FOUR;
         end
         S_BRANCH: begin
            alu_src_a = SRC_A_REG;
            alu_class = ALU_CLASS_SUB;
            pc_write  = branch_taken(func3, zero, neg);
         end
         S_LUI: begin
            result_src = RES_IMM;
            reg_write  = 1'b1;
         end
         default: ;
      endcase
   end

   assign imm_src = decode_imm_src(op_code);

   multi_alu_decoder u_alu_decoder (
      .alu_class   (alu_class),
      .func3       (func3),
      .func7       (func7),
      .alu_control (alu_control)
   );

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Self-checking bench: each instruction class is expanded into the per-cycle
// control words it must produce, and the DUT is compared cycle by cycle.
module tb_multi_cycle_controller;

   typedef enum int {K_R, K_I, K_LW, K_SW, K_JAL, K_JALR, K_BR, K_LUI, K_ILL} kind_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  op_code;
   logic [2:0]  func3;
   logic [6:0]  func7;
   logic        zero;
   logic        neg;
   logic        pc_write, adr_src, mem_write, ir_write, reg_write;
   logic [1:0]  result_src, alu_src_a, alu_src_b;
   logic [2:0]  imm_src, alu_control;
   logic [16:0] ctl;

   int n_checks = 0;
   int n_pass   = 0;

   multi_cycle_controller dut (
      .clk         (clk),
      .rst         (rst),
      .op_code     (op_code),
      .func3       (func3),
      .func7       (func7),
      .zero        (zero),
      .neg         (neg),
      .pc_write    (pc_write),
      .adr_src     (adr_src),
      .mem_write   (mem_write),
      .ir_write    (ir_write),
      .reg_write   (reg_write),
      .result_src  (result_src),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .imm_src     (imm_src),
      .alu_control (alu_control)
   );

   always #5 clk = ~clk;

   assign ctl = {pc_write, adr_src, mem_write, ir_write, reg_write,
                 result_src, alu_src_a, alu_src_b, imm_src, alu_control};

   task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %05h expected %05h", tag, got, exp);
   endtask

   function automatic kind_t classify(input logic [6:0] op);
      case (op)
         7'b0110011: return K_R;
         7'b0010011: return K_I;
         7'b0000011: return K_LW;
         7'b0100011: return K_SW;
         7'b1101111: return K_JAL;
         7'b1100111: return K_JALR;
         7'b1100011: return K_BR;
         7'b0110111: return K_LUI;
         default:    return K_ILL;
      endcase
   endfunction

   function automatic int instr_len(input kind_t k);
      case (k)
         K_LW, K_JALR:        return 5;
         K_R, K_I, K_SW, K_JAL: return 4;
         K_BR, K_LUI:         return 3;
         default:             return 2;
      endcase
   endfunction

   function automatic logic [2:0] ref_imm(input logic [6:0] op);
      case (classify(op))
         K_SW:    return 3'b001;
         K_BR:    return 3'b010;
         K_JAL:   return 3'b011;
         K_LUI:   return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [2:0] ref_alu(input bit is_r, input logic [2:0] f3, input logic [6:0] f7);
      case (f3)
         3'b000:  return (is_r && f7[5]) ? 3'b001 : 3'b000;
         3'b111:  return 3'b010;
         3'b110:  return 3'b011;
         3'b010:  return 3'b100;
         3'b100:  return 3'b101;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic ref_taken(input logic [2:0] f3, input logic z, input logic n);
      case (f3)
         3'b000:  return z;
         3'b001:  return ~z;
         3'b100:  return n;
         3'b101:  return ~n;
         default: return 1'b0;
      endcase
   endfunction

   // Expected control word for the given cycle (0 = fetch) of an instruction.
   function automatic logic [16:0] exp_out(input logic [6:0] op, input int step,
                                           input logic [2:0] f3, input logic [6:0] f7,
                                           input logic z, input logic n);
      logic pc = 0, adr = 0, mw = 0, irw = 0, rw = 0;
      logic [1:0] rs = 0, a = 0, b = 0;
      logic [2:0] alu = 0;
      kind_t k = classify(op);
      if (step == 0) begin
         irw = 1; pc = 1; b = 2; rs = 2;
      end else if (step == 1) begin
         a = 1; b = 1;
      end else begin
         case (k)
            K_R:  if (step == 2) begin a = 2; alu = ref_alu(1, f3, f7); end else rw = 1;
            K_I:  if (step == 2) begin a = 2; b = 1; alu = ref_alu(0, f3, f7); end else rw = 1;
            K_LW: if (step == 2) begin a = 2; b = 1; end
                  else if (step == 3) adr = 1;
                  else begin rs = 1; rw = 1; end
            K_SW: if (step == 2) begin a = 2; b = 1; end else begin adr = 1; mw = 1; end
            K_JAL: if (step == 2) begin pc = 1; a = 1; b = 2; end else rw = 1;
            K_JALR: if (step == 2) begin a = 2; b = 1; end
                    else if (step == 3) begin pc = 1; a = 1; b = 2; end
                    else rw = 1;
            K_BR:  begin a = 2; alu = 3'b001; pc = ref_taken(f3, z, n); end
            K_LUI: begin rs = 3; rw = 1; end
            default: ;
         endcase
      end
      return {pc, adr, mw, irw, rw, rs, a, b, ref_imm(op), alu};
   endfunction

   // Runs up to max_steps cycles of one instruction; entered and left at posedge+1.
   task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic z, input logic n,
                            input bit rnd_flags, input int max_steps);
      int len = instr_len(classify(op));
      if (max_steps < len) len = max_steps;
      for (int s = 0; s < len; s++) begin
         op_code = op; func3 = f3; func7 = f7;
         zero = rnd_flags ? 1'($urandom_range(0, 1)) : z;
         neg  = rnd_flags ? 1'($urandom_range(0, 1)) : n;
         @(negedge clk);
         check($sformatf("%s step%0d", name, s), ctl, exp_out(op, s, f3, f7, zero, neg));
         @(posedge clk); #1;
      end
   endtask

   logic [6:0] legal_ops [8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                 7'b1101111, 7'b1100111, 7'b1100011, 7'b0110111};

   initial begin
      logic [6:0] op, f7;
      logic [2:0] f3;
      rst = 1'b1; op_code = '0; func3 = '0; func7 = '0; zero = 0; neg = 0;
      @(posedge clk); #1;
      @(negedge clk);
      check("reset", ctl, exp_out(7'b0, 0, 3'b0, 7'b0, 0, 0));
      @(posedge clk); #1;
      rst = 1'b0;

      // Reset held two cycles while a load sits in MEM_READ.
      run_instr("lw_pre_reset", 7'b0000011, 3'b010, 7'b0, 0, 0, 0, 3);
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("reset_mid_instr", ctl, exp_out(7'b0000011, 0, 3'b010, 7'b0, 0, 0));
      @(posedge clk); #1;
      rst = 1'b0;

      run_instr("add",     7'b0110011, 3'b000, 7'b0000000, 0, 0, 0, 99);
      run_instr("sub",     7'b0110011, 3'b000, 7'b0100000, 0, 0, 0, 99);
      run_instr("addi",    7'b0010011, 3'b000, 7'b0100000, 0, 0, 0, 99);
      run_instr("lw",      7'b0000011, 3'b010, 7'b0, 0, 0, 0, 99);
      run_instr("sw",      7'b0100011, 3'b010, 7'b0, 0, 0, 0, 99);
      run_instr("beq_t",   7'b1100011, 3'b000, 7'b0, 1, 0, 0, 99);
      run_instr("beq_nt",  7'b1100011, 3'b000, 7'b0, 0, 0, 0, 99);
      run_instr("bge_nt",  7'b1100011, 3'b101, 7'b0, 0, 1, 0, 99);
      run_instr("bne_t",   7'b1100011, 3'b001, 7'b0, 0, 0, 0, 99);
      run_instr("blt_t",   7'b1100011, 3'b100, 7'b0, 0, 1, 0, 99);
      run_instr("bltu_nt", 7'b1100011, 3'b110, 7'b0, 1, 1, 0, 99);
      run_instr("jal",     7'b1101111, 3'b000, 7'b0, 0, 0, 0, 99);
      run_instr("jalr",    7'b1100111, 3'b000, 7'b0, 0, 0, 0, 99);
      run_instr("lui",     7'b0110111, 3'b000, 7'b0, 0, 0, 0, 99);
      run_instr("illegal", 7'b0000000, 3'b000, 7'b0, 0, 0, 0, 99);

      for (int i = 0; i < 300; i++) begin
         int idx = int'($urandom_range(0, 9));
         op = (idx < 8) ? legal_ops[idx] : 7'($urandom_range(0, 127));
         f3 = 3'($urandom_range(0, 7));
         f7 = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'($urandom_range(0, 127));
         run_instr($sformatf("rnd%0d_op%02h", i, op), op, f3, f7, 0, 0, 1, 99);
      end

      // The last instruction must have returned the FSM to FETCH.
      run_instr("final_fetch", 7'b0000000, 3'b000, 7'b0, 0, 0, 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
